// File: rtl/signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : signal_sequencer
// Purpose  : Pattern table playback. Each entry is shown as a load/D pair and
//            sent as a serial bit stream, one bit per clock, D[0] first.
// Option   : define SIGNAL_SEQUENCER_LOOP_EN so the loop input can replay the
//            table from entry 0.
// Revision : 1.0 - initial release
// ============================================================================
module signal_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [0:3]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic [AW:0]   len,
  input  logic          loop,
  output logic          load,
  output logic [0:3]    D,
  output logic          out,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_LOAD  = 2'd1;
  localparam logic [1:0]  c_SHIFT = 2'd2;
  localparam logic [1:0]  c_DONE  = 2'd3;
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ONE   = (AW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [0:3]    table_q [DEPTH];
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    bit_q, bit_d;
  logic          load_q, load_d;
  logic [0:3]    d_q, d_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_loop;
  logic          w_last;
  logic          w_wr;
  logic          w_enter_load;
  logic [AW-1:0] w_ld_idx;
  logic [AW:0]   w_len_clamp;

`ifdef SIGNAL_SEQUENCER_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = loop & 1'b0;
`endif

  assign w_last      = ({1'b0, idx_q} == (len_q - c_ONE));
  assign w_len_clamp = (len > c_DEPTH) ? c_DEPTH : len;
  // busy is low in IDLE and DONE, the only states that accept table writes.
  assign w_wr        = wr_en && !busy_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    bit_d        = bit_q;
    load_d       = 1'b0;
    d_d          = d_q;
    out_d        = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    w_enter_load = 1'b0;
    w_ld_idx     = idx_q;

    case (state_q)
      c_IDLE: begin
        d_d = '0;
        if (start && !stop && (len != '0)) begin
          len_d        = w_len_clamp;
          w_enter_load = 1'b1;
          w_ld_idx     = '0;
        end
      end
      c_LOAD: begin
        state_d = c_SHIFT;
        bit_d   = 2'd1;
        out_d   = d_q[1];
        busy_d  = 1'b1;
      end
      c_SHIFT: begin
        busy_d = 1'b1;
        if (bit_q != 2'd3) begin
          bit_d = bit_q + 2'd1;
          out_d = d_q[bit_q + 2'd1];
        end else if (!w_last) begin
          w_enter_load = 1'b1;
          w_ld_idx     = idx_q + AW'(1);
        end else if (w_loop) begin
          w_enter_load = 1'b1;
          w_ld_idx     = '0;
        end else begin
          state_d = c_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        idx_d   = '0;
        bit_d   = '0;
        d_d     = '0;
      end
      default: begin
        state_d = c_IDLE;
        d_d     = '0;
      end
    endcase

    // Outputs are registered, so a slot's first-cycle values are staged here.
    if (w_enter_load) begin
      state_d = c_LOAD;
      idx_d   = w_ld_idx;
      bit_d   = 2'd0;
      load_d  = 1'b1;
      d_d     = table_q[w_ld_idx];
      out_d   = table_q[w_ld_idx][0];
      busy_d  = 1'b1;
    end

    if (stop && (state_q != c_IDLE)) begin
      state_d = c_IDLE;
      idx_d   = '0;
      bit_d   = '0;
      load_d  = 1'b0;
      d_d     = '0;
      out_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      load_q  <= 1'b0;
      d_q     <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      load_q  <= load_d;
      d_q     <= d_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (w_wr) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign load = load_q;
  assign D    = d_q;
  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
